// File: rtl/ram_bridge_pkg.sv
// ram_bridge_pkg: shared definitions for the RAM byte bridge.
//   state_t          bridge FSM encoding (IDLE, RD, RSP)
//   GNT_HOST/GNT_BUS grant encoding produced by the arbiter
//   lane_byte()      extract byte n from a RAM word (zero-extended to LANE_MAX_W)
package ram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic GNT_HOST = 1'b0;
  localparam logic GNT_BUS  = 1'b1;

  // Widest word the lane helper accepts; callers zero-extend into this.
  localparam int unsigned LANE_MAX_BYTES = 64;
  localparam int unsigned LANE_MAX_W     = 8 * LANE_MAX_BYTES;

  function automatic logic [7:0] lane_byte(input logic [LANE_MAX_W-1:0] word,
                                           input int unsigned           n);
    return word[8*n +: 8];
  endfunction

endpackage

// File: rtl/ram_bridge_arb.sv
// ram_bridge_arb: grant logic for the host / bus requesters.
//   clk, rst_n  only present when RAM_BYTE_BRIDGE_RR_ARB_EN is defined
//   host_req    host request
//   bus_req     bus request
//   idle        bridge can take a new request this cycle
//   gnt_vld     a request is granted this cycle
//   gnt         which requester (GNT_HOST / GNT_BUS)
// Optional macro RAM_BYTE_BRIDGE_RR_ARB_EN: round-robin on contention.
// Without it the host always wins and no state is kept.
module ram_bridge_arb
  import ram_bridge_pkg::*;
(
`ifdef RAM_BYTE_BRIDGE_RR_ARB_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic host_req,
  input  logic bus_req,
  input  logic idle,
  output logic gnt_vld,
  output logic gnt
);

  assign gnt_vld = idle && (host_req || bus_req);

`ifdef RAM_BYTE_BRIDGE_RR_ARB_EN
  logic contended;
  logic rr_prio;   // requester that wins the next contended grant

  assign contended = idle && host_req && bus_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_prio <= GNT_HOST;
    end else if (contended) begin
      rr_prio <= ~rr_prio;
    end
  end

  always_comb begin
    gnt = host_req ? GNT_HOST : GNT_BUS;
    if (contended) begin
      gnt = rr_prio;
    end
  end
`else
  assign gnt = host_req ? GNT_HOST : GNT_BUS;
`endif

endmodule

// File: rtl/ram_byte_bridge.sv
// ram_byte_bridge: arbitrated bridge in front of a single-port word RAM
// with per-byte write enables.
//   host_*      byte-wide valid/ready port; reads answer with a one-cycle
//               host_rsp_valid pulse two cycles after accept, writes are
//               posted (one per cycle, no response)
//   bus_*       word-wide Wishbone-classic style port; bus_ack one cycle
//               after grant for writes, two cycles for reads
//   ram_*       RAM macro interface; ram_do valid one cycle after ram_en
// Optional macro RAM_BYTE_BRIDGE_RR_ARB_EN: round-robin arbitration on
// contention instead of fixed host priority.
module ram_byte_bridge
  import ram_bridge_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LANE_W      = $clog2(WORD_BYTES),
  parameter int unsigned WADDR_W     = $clog2(DEPTH_WORDS),
  parameter int unsigned HADDR_W     = WADDR_W + LANE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic                    host_we,
  input  logic [HADDR_W-1:0]      host_addr,
  input  logic [7:0]              host_wdata,
  output logic                    host_rsp_valid,
  output logic [7:0]              host_rsp_data,
  input  logic                    bus_cyc,
  input  logic [WADDR_W-1:0]      bus_adr,
  input  logic                    bus_we,
  input  logic [WORD_BYTES-1:0]   bus_sel,
  input  logic [8*WORD_BYTES-1:0] bus_dat,
  output logic [8*WORD_BYTES-1:0] bus_rdt,
  output logic                    bus_ack,
  output logic                    ram_en,
  output logic [WADDR_W-1:0]      ram_a,
  output logic [WORD_BYTES-1:0]   ram_we,
  output logic [8*WORD_BYTES-1:0] ram_di,
  input  logic [8*WORD_BYTES-1:0] ram_do
);

  state_t              state, state_nxt;
  logic                owner_p1;   // requester of the transaction in flight
  logic [LANE_W-1:0]   lane_p1;    // host byte lane of the read in flight
  logic                idle;
  logic                gnt_vld;
  logic                gnt;
  logic [LANE_W-1:0]   host_lane;

  assign host_lane = host_addr[LANE_W-1:0];

  // Gating with rst_n keeps every RAM strobe and host_ready low for the
  // whole time reset is held, not just after the first clock.
  assign idle = rst_n && (state == IDLE);

  ram_bridge_arb u_arb (
`ifdef RAM_BYTE_BRIDGE_RR_ARB_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .host_req (host_valid),
    .bus_req  (bus_cyc),
    .idle     (idle),
    .gnt_vld  (gnt_vld),
    .gnt      (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    ram_en     = 1'b0;
    ram_a      = '0;
    ram_we     = '0;
    ram_di     = '0;
    case (state)
      IDLE: begin
        // Ready unless the bus takes this cycle while the host is asking.
        host_ready = idle && !(host_valid && (gnt == GNT_BUS));
        if (gnt_vld) begin
          ram_en = 1'b1;
          if (gnt == GNT_HOST) begin
            ram_a = host_addr[HADDR_W-1:LANE_W];
            if (host_we) begin
              ram_we = {{(WORD_BYTES-1){1'b0}}, 1'b1} << host_lane;
              ram_di = {WORD_BYTES{host_wdata}};
            end else begin
              state_nxt = RD;
            end
          end else begin
            ram_a = bus_adr;
            if (bus_we) begin
              ram_we    = bus_sel;
              ram_di    = bus_dat;
              state_nxt = RSP;
            end else begin
              state_nxt = RD;
            end
          end
        end
      end
      RD:      state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign host_rsp_valid = (state == RSP) && (owner_p1 == GNT_HOST);
  assign bus_ack        = (state == RSP) && (owner_p1 == GNT_BUS);

  // Grant stage -> RD stage: remember owner and lane of the request.
  // RD stage -> RSP stage: capture RAM read data into the owner's register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_p1      <= GNT_HOST;
      lane_p1       <= '0;
      host_rsp_data <= '0;
      bus_rdt       <= '0;
    end else begin
      if (gnt_vld) begin
        owner_p1 <= gnt;
        lane_p1  <= host_lane;
      end
      if (state == RD) begin
        if (owner_p1 == GNT_HOST) begin
          host_rsp_data <= lane_byte(LANE_MAX_W'(ram_do), 32'(lane_p1));
        end else begin
          bus_rdt <= ram_do;
        end
      end
    end
  end

endmodule

// File: doc/ram_byte_bridge.md
Name: ram_byte_bridge

Overview:
- Parametrised, arbitrated access bridge in front of a single-port, word-wide synchronous RAM macro with per-byte write enables (RAM32-class).
- Serves two requesters:
  - a byte-wide host port, driven from the chip's dedicated pins;
  - a word-wide Wishbone-classic-style bus port, driven by the on-chip CPU's ibus/dbus.
- Replaces direct pin-to-macro wiring. Adds a request/response handshake, registered read data and arbitration, so the CPU and the external host can share one RAM macro.

Parameters:
- WORD_BYTES, 4: bytes per RAM word. Power of two, ≥2.
- DEPTH_WORDS, 32: RAM depth in words. Power of two.
- LANE_W, $clog2(WORD_BYTES): derived. Byte-lane index width.
- WADDR_W, $clog2(DEPTH_WORDS): derived. Word address width.
- HADDR_W, WADDR_W+LANE_W: derived. Host byte address width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_valid  in  1  host request present.
- host_ready  out  1  host request accepted this cycle when host_valid is also high.
- host_we  in  1  1 = byte write, 0 = byte read.
- host_addr  in  HADDR_W  byte address; low LANE_W bits select the lane.
- host_wdata  in  8  write byte.
- host_rsp_valid  out  1  one-cycle pulse; host_rsp_data is valid in that cycle.
- host_rsp_data  out  8  read byte.
- bus_cyc  in  1  bus request; held high until bus_ack.
- bus_adr  in  WADDR_W  word address.
- bus_we  in  1  write strobe.
- bus_sel  in  WORD_BYTES  byte enables for writes.
- bus_dat  in  8*WORD_BYTES  write data.
- bus_rdt  out  8*WORD_BYTES  read data, valid while bus_ack is high.
- bus_ack  out  1  one-cycle acknowledge.
- ram_en  out  1  RAM enable.
- ram_a  out  WADDR_W  RAM word address.
- ram_we  out  WORD_BYTES  per-byte write enables.
- ram_di  out  8*WORD_BYTES  RAM write data.
- ram_do  in  8*WORD_BYTES  RAM read data, valid one cycle after an enabled read.

Behaviour:
- Reset: asynchronous, active-low. Takes effect immediately.
  - FSM goes to IDLE.
  - host_ready=0 while rst_n is low; it returns to 1 in the first cycle after release.
  - host_rsp_valid=0, host_rsp_data=0.
  - bus_ack=0, bus_rdt=0.
  - ram_en=0, ram_we=0, ram_a=0, ram_di=0.
  - Round-robin pointer = host.
  - An in-flight read is dropped and produces no response or ack.
- FSM states: IDLE, RD (RAM read in flight), RSP (response/ack cycle).
- IDLE:
  - host_ready=1.
  - Grant is decided combinationally from host_valid and bus_cyc.
  - The granted request drives ram_en=1 and ram_a in the same cycle.
- Host write:
  - ram_a = host_addr[HADDR_W-1:LANE_W].
  - ram_we is one-hot at lane host_addr[LANE_W-1:0].
  - ram_di = host_wdata replicated across all lanes.
  - FSM stays in IDLE, so back-to-back host writes run at one per cycle.
  - No host response is generated.
- Host read:
  - IDLE→RD→RSP→IDLE.
  - The lane index is registered at grant.
  - In RD, the selected byte of ram_do is captured into host_rsp_data.
  - In RSP, host_rsp_valid=1 for exactly one cycle.
  - Latency is 2 cycles from the accept edge. host_ready=0 in RD and RSP.
- Bus write:
  - ram_we = bus_sel and ram_di = bus_dat, at word address bus_adr.
  - IDLE→RSP; bus_ack is high in RSP, one cycle after the grant.
  - bus_sel=0 still produces an ack, with no RAM change.
- Bus read:
  - IDLE→RD→RSP; ram_do is captured into bus_rdt in RD.
  - bus_ack is high in RSP, 2 cycles after the grant.
- RSP always returns to IDLE. A bus_cyc still high during its own ack cycle is therefore never re-granted.
- Arbitration: fixed host priority. If host_valid and bus_cyc are both high in IDLE, the host wins and the bus waits.
  - Host writes hold IDLE, so sustained host writes starve the bus. This is accepted; the host is the debug master.
- Address range: addresses wrap by truncation; every address is in range because the widths are exact.
- host_rsp_data and bus_rdt hold their last value outside their valid cycle.

Optional Feature:
- Macro: RAM_BYTE_BRIDGE_RR_ARB_EN.
- Defined:
  - Round-robin arbitration on contention in IDLE.
  - A 1-bit last-grant register flips on every contended grant.
  - The requester not granted last wins the next contended grant.
  - Uncontended requests are granted immediately.
- Undefined: fixed host priority, and no pointer register is synthesised.

Decomposition:
- Shared package ram_bridge_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RD=2'd1, RSP=2'd2);
  - grant encoding constants GNT_HOST and GNT_BUS;
  - lane-select helper function: byte n of a WORD_BYTES word.
- Sub-module ram_bridge_arb: the arbiter. Inputs are the two requests and the FSM-idle flag; output is the grant. It contains the optional round-robin pointer.

Test Plan (defaults WORD_BYTES=4, DEPTH_WORDS=32):
1. Host write 0xA5 @0x05 → that cycle ram_a=1, ram_we=4'b0010, ram_di=0xA5A5A5A5. Then host read @0x05 → host_rsp_valid 2 cycles after accept, data 0xA5.
2. Bus write adr 3, dat 0xDEADBEEF, sel 4'hF → bus_ack 1 cycle later. Host reads @0x0C/0x0F → 0xEF/0xDE.
3. Host read @0x00 and bus read adr 0 requested in the same IDLE cycle N (fixed priority) → host_rsp_valid at N+2, bus granted at N+3, bus_ack at N+5.
4. With RAM_BYTE_BRIDGE_RR_ARB_EN, both ports requesting reads continuously → grants alternate host, bus, host, bus.
5. rst_n low while in RD of a host read → no host_rsp_valid. host_ready=0 during reset, host_ready=1 the cycle after release.
6. Host write 0x3C @0x7F, then read @0x7F → ram_a=31, ram_we=4'b1000, response 0x3C.
